// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single ready/valid data memory port.
// One transaction in flight; a response timeout turns a hung memory into an all-ones error reply.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_valid,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_valid,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy,
  output logic                timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [1:0]        state;
  logic              grant;
  logic              last_grant;
  logic [TW-1:0]     timer;

  logic              req_any;
  logic              winner;
  logic              expire;
  logic              done;
  logic [DATA_W-1:0] resp_data;

  // A real response in the expiry cycle takes priority over the timeout.
  always_comb begin
    req_any   = m0_ready | m1_ready;
    winner    = (m0_ready && m1_ready) ? ~last_grant : m1_ready;
    expire    = (TIMEOUT != 0) && (timer == TLAST);
    done      = mem_valid || expire;
    resp_data = mem_valid ? mem_rdata : '1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      timer       <= '0;
      mem_ready   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      m0_valid    <= 1'b0;
      m0_rdata    <= '0;
      m1_valid    <= 1'b0;
      m1_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      m0_valid    <= 1'b0;
      m1_valid    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            mem_addr   <= winner ? m1_addr  : m0_addr;
            mem_wdata  <= winner ? m1_wdata : m0_wdata;
            mem_wstrb  <= winner ? m1_wstrb : m0_wstrb;
            mem_ready  <= 1'b1;
            grant      <= winner;
            last_grant <= winner;
            timer      <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (done) begin
            mem_ready   <= 1'b0;
            timeout_err <= ~mem_valid;
            state       <= RESP;
            // The response pulse is registered here so it is visible in the RESP cycle.
            if (grant) begin
              m1_valid <= 1'b1;
              m1_rdata <= resp_data;
            end else begin
              m0_valid <= 1'b1;
              m0_rdata <= resp_data;
            end
          end else if (TIMEOUT != 0) begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized two-requester traffic checked against per-requester shadow memories.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        busy, timeout_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_valid(m0_valid), .m0_rdata(m0_rdata),
    .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_valid(m1_valid), .m1_rdata(m1_rdata),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    bit          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;      // memory response delay after first mem_ready cycle; 0 = hung
    logic [31:0] exp_rdata;
    int          exp_lat;    // cycle of the requester's valid, request raised in cycle 0
    int          exp_rdy;    // cycles with mem_ready high
    int          exp_to;     // timeout_err pulses
  } vec_t;

  int          total = 0;
  int          bad   = 0;

  logic [31:0] mem_arr [256];
  logic [31:0] shadow  [128];
  int          mem_delay  = 1;
  bit          rand_delay = 0;
  int          inject_req  = 0;
  int          inject_done = 0;
  bit          mon_en = 0;
  bit          m_last;
  bit          p_idle, p_r0, p_r1;
  logic [31:0] p_a0, p_a1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  task automatic responder();
    int          remain = 0;
    bit          pv;
    int          d;
    logic [7:0]  idx = '0;
    forever begin
      @(posedge clk); #1;
      pv = mem_valid;
      mem_valid = 1'b0;
      if (reset) remain = 0;
      if (inject_req != inject_done) begin
        inject_done++;
        mem_valid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
      end
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem_arr[idx];
        end
      end else if (!reset && mem_ready && !pv) begin
        d = rand_delay ? int'($urandom_range(1, 3)) : mem_delay;
        if (d > 0) begin
          remain = d;
          idx = mem_addr[9:2];
          mem_arr[idx] = merge(mem_arr[idx], mem_wdata, mem_wstrb);
        end
      end
    end
  endtask

  // Grant-rule and mutual-exclusion monitor for the randomized phase.
  task automatic monitor();
    bit          win;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("dual_valid", {31'b0, m0_valid & m1_valid}, 32'd0);
        if (p_idle && (p_r0 || p_r1)) begin
          win = (p_r0 && p_r1) ? ~m_last : p_r1;
          m_last = win;
          check("grant_ready", {31'b0, mem_ready}, 32'd1);
          check("grant_addr", mem_addr, win ? p_a1 : p_a0);
        end
      end
      p_idle = !busy && !reset;
      p_r0 = m0_ready;
      p_r1 = m1_ready;
      p_a0 = m0_addr;
      p_a1 = m1_addr;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valids", {30'b0, m1_valid, m0_valid}, 32'd0);
    check("rst_timeout", {31'b0, timeout_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drive(input bit id, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (id) begin
      m1_ready = r; m1_addr = a; m1_wdata = d; m1_wstrb = s;
    end else begin
      m0_ready = r; m0_addr = a; m0_wdata = d; m0_wstrb = s;
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int vc = -1, fc = -1, tc = -1, rdy = 0, nv = 0, ov = 0, to = 0;
    logic [31:0] rd = '0, fa = '0, fw = '0;
    logic [3:0]  fs = '0;
    bit own, oth;
    mem_delay = v.delay;
    drive(v.id, 1'b1, v.addr, v.wdata, v.wstrb);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      own = v.id ? m1_valid : m0_valid;
      oth = v.id ? m0_valid : m1_valid;
      if (mem_ready) begin
        rdy++;
        if (rdy == 1) begin fc = c; fa = mem_addr; fw = mem_wdata; fs = mem_wstrb; end
      end
      if (own) begin
        nv++;
        if (vc < 0) begin vc = c; rd = v.id ? m1_rdata : m0_rdata; end
      end
      if (oth) ov++;
      if (timeout_err) begin to++; tc = c; end
      @(posedge clk); #1;
      if (vc >= 0) drive(v.id, 1'b0, v.addr, v.wdata, v.wstrb);
    end
    check($sformatf("v%0d_latency", n), 32'(vc), 32'(v.exp_lat));
    check($sformatf("v%0d_rdata", n), rd, v.exp_rdata);
    check($sformatf("v%0d_valid_count", n), 32'(nv), 32'd1);
    check($sformatf("v%0d_other_valid", n), 32'(ov), 32'd0);
    check($sformatf("v%0d_ready_cycles", n), 32'(rdy), 32'(v.exp_rdy));
    check($sformatf("v%0d_ready_first", n), 32'(fc), 32'd1);
    check($sformatf("v%0d_mem_addr", n), fa, v.addr);
    check($sformatf("v%0d_mem_wdata", n), fw, v.wdata);
    check($sformatf("v%0d_mem_wstrb", n), {28'b0, fs}, {28'b0, v.wstrb});
    check($sformatf("v%0d_timeout_count", n), 32'(to), 32'(v.exp_to));
    if (v.exp_to != 0) check($sformatf("v%0d_timeout_cycle", n), 32'(tc), 32'(vc));
    check($sformatf("v%0d_rdata_hold", n), v.id ? m1_rdata : m0_rdata, v.exp_rdata);
  endtask

  task automatic late_response();
    int nv = 0, nb = 0, nt = 0;
    inject_req++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m0_valid || m1_valid) nv++;
      if (busy) nb++;
      if (timeout_err) nt++;
    end
    @(posedge clk); #1;
    check("late_valid", 32'(nv), 32'd0);
    check("late_busy", 32'(nb), 32'd0);
    check("late_timeout", 32'(nt), 32'd0);
  endtask

  task automatic agent(input bit id, input int n);
    logic [31:0] a, d, exp, got;
    logic [3:0]  s;
    int          idx, gap;
    bit          seen;
    for (int t = 0; t < n; t++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      idx = (id ? 64 : 0) + int'($urandom_range(0, 63));
      a = 32'(idx) << 2;
      d = $urandom;
      s = $urandom_range(0, 1) ? 4'(($urandom_range(1, 15))) : 4'h0;
      exp = merge(shadow[idx], d, s);
      shadow[idx] = exp;
      drive(id, 1'b1, a, d, s);
      seen = 1'b0;
      got = '0;
      for (int w = 0; w < 30 && !seen; w++) begin
        @(negedge clk);
        if (id ? m1_valid : m0_valid) begin
          seen = 1'b1;
          got = id ? m1_rdata : m0_rdata;
        end
      end
      @(posedge clk); #1;
      drive(id, 1'b0, a, d, s);
      check($sformatf("rand_a%0d_response", id), {31'b0, seen}, 32'd1);
      if (seen) check($sformatf("rand_a%0d_rdata", id), got, exp);
    end
  endtask

  initial begin
    vec_t vecs [6];
    int   order [4];
    int   nresp, ndual;
    bit   got0;

    reset = 1'b1;
    mem_valid = 1'b0;
    mem_rdata = '0;
    m0_ready = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_ready = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'(i) * 32'h01010101;
    mem_arr[255] = 32'h00000005;
    mem_arr[4]   = 32'h11223344;
    mem_arr[8]   = 32'hCAFEF00D;

    vecs[0] = '{1'b0, 32'h3FC, 32'h0,        4'b0000, 1, 32'h00000005, 3, 2, 0};
    vecs[1] = '{1'b1, 32'h010, 32'hA5A5A5A5, 4'b0011, 1, 32'h1122A5A5, 3, 2, 0};
    vecs[2] = '{1'b0, 32'h020, 32'hFFFFFFFF, 4'b1000, 2, 32'hFFFEF00D, 4, 3, 0};
    vecs[3] = '{1'b1, 32'h3FC, 32'h0,        4'b0000, 3, 32'h00000005, 5, 4, 0};
    vecs[4] = '{1'b0, 32'h040, 32'h0,        4'b0000, 0, 32'hFFFFFFFF, 5, 4, 1};
    vecs[5] = '{1'b1, 32'h044, 32'h00000001, 4'b1111, 0, 32'hFFFFFFFF, 5, 4, 1};

    fork
      responder();
      monitor();
    join_none

    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
      if (vecs[i].exp_to != 0 && i == 4) late_response();
    end

    // Contention: both requesters held high continuously from reset.
    do_reset();
    mem_delay = 1;
    drive(1'b0, 1'b1, 32'h100, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h104, 32'h0, 4'h0);
    nresp = 0;
    ndual = 0;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      @(negedge clk);
      if (m0_valid && m1_valid) ndual++;
      if (m0_valid || m1_valid) begin
        order[nresp] = m1_valid ? 1 : 0;
        nresp++;
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    check("rr_count", 32'(nresp), 32'd4);
    check("rr_dual", 32'(ndual), 32'd0);
    for (int i = 0; i < nresp; i++)
      check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
    repeat (3) @(posedge clk);
    #1;

    // Reset while m0 is being served by a hung memory.
    mem_delay = 0;
    drive(1'b0, 1'b1, 32'h0C0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    check("rstiss_pre_ready", {31'b0, mem_ready}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rstiss_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("rstiss_busy", {31'b0, busy}, 32'd0);
    check("rstiss_valids", {30'b0, m1_valid, m0_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0C0, 32'h0, 4'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_delay = 1;
    drive(1'b0, 1'b1, 32'h0C0, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h0C4, 32'h0, 4'h0);
    nresp = 0;
    got0 = 1'b0;
    for (int c = 0; c < 20 && nresp == 0; c++) begin
      @(negedge clk);
      if (m0_valid || m1_valid) begin
        nresp++;
        got0 = m0_valid && !m1_valid;
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0C0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0C4, 32'h0, 4'h0);
    check("rstiss_resp_seen", 32'(nresp), 32'd1);
    check("rstiss_first_m0", {31'b0, got0}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic on disjoint address halves.
    do_reset();
    for (int i = 0; i < 128; i++) begin
      mem_arr[i] = $urandom;
      shadow[i]  = mem_arr[i];
    end
    m_last = 1'b1;
    rand_delay = 1'b1;
    mon_en = 1'b1;
    fork
      agent(1'b0, 30);
      agent(1'b1, 30);
    join
    mon_en = 1'b0;
    rand_delay = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter sharing the single littlecpu-style data memory port (request = `*_ready`, response = single-cycle `*_valid`). Requester 0 is the CPU data port; requester 1 is a secondary master (loader/DMA/debug). Round-robin grant, one outstanding transaction, registered outputs, and a response timeout that converts a hung memory into an error response instead of a deadlock.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wstrb width is DATA_W/8
TIMEOUT, 16, max cycles in ISSUE waiting for mem_valid; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
m0_ready  in  1  requester 0 request; held high with addr/wdata/wstrb stable until m0_valid
m0_addr  in  ADDR_W  requester 0 address
m0_wdata  in  DATA_W  requester 0 write data
m0_wstrb  in  DATA_W/8  requester 0 byte strobes; 0 = read
m0_valid  out  1  one-cycle response pulse to requester 0
m0_rdata  out  DATA_W  read data, valid while m0_valid
m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_valid, m1_rdata: same as m0_*, for requester 1
mem_ready  out  1  request to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory byte strobes
mem_valid  in  1  memory one-cycle response
mem_rdata  in  DATA_W  memory read data
busy  out  1  high when state != IDLE
timeout_err  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset (async): state=IDLE; all outputs 0; last_grant=1 (requester 0 wins the first contention); timer=0.
- States: IDLE, ISSUE, RESP.
- IDLE: sample m0_ready/m1_ready.
  - Neither high: stay in IDLE.
  - One high: grant it.
  - Both high: grant the one != last_grant.
  - On grant: register its addr/wdata/wstrb onto mem_*; mem_ready<=1; grant<=winner; last_grant<=winner; timer<=0; go to ISSUE.
- ISSUE: mem_ready held high; mem_* held constant.
  - mem_valid=1: capture mem_rdata; mem_ready<=0; go to RESP.
  - Else, if TIMEOUT!=0 and timer==TIMEOUT-1: mem_ready<=0; response data = all-ones; timeout_err<=1 for one cycle; go to RESP.
  - Else: timer++.
  - mem_valid and expiry in the same cycle: mem_valid wins, no error.
- RESP: mX_valid=1 for exactly one cycle, only for the granted requester, with mX_rdata = captured data. Next state is IDLE. mX_rdata holds its value after the pulse until the next response to that requester.
- Latency, uncontended, memory responding in the cycle after its request:
  - Request high in cycle 0 (IDLE) → mem_ready high in cycle 1.
  - mem_valid in cycle 2 → mX_valid in cycle 3.
  - Earliest next grant evaluation is cycle 4.
- mem_ready deasserts in the cycle after mem_valid, so a memory that re-accepts on (!mem_valid && mem_ready) never sees a duplicate request.
- Requesters must drop `*_ready` in the cycle after their `*_valid`. A request still high in IDLE is treated as a new transaction.
- A requester dropping `*_ready` while granted does not abort the transaction; the response pulse is still issued.
- mem_valid outside ISSUE is ignored. This covers a late response after a timeout.
- Writes return captured mem_rdata like reads; the arbiter does not interpret wstrb.
- Reset asserted mid-transaction: immediate return to reset values; no valid pulse is generated.

Test Plan:
- Single read: m0 requests addr 0x3FC while memory holds 0x00000005 → mem_ready high in cycle 1 with mem_addr=0x3FC, mem_wstrb=0; m0_valid pulses in cycle 3 with m0_rdata=0x00000005; m1_valid stays 0.
- Write: m1 requests addr 0x10, wdata 0xA5A5A5A5, wstrb 4'b0011 → memory word 0x10 low half becomes 0xA5A5; m1_valid pulses once; mem_ready high for exactly 2 cycles.
- Contention: both request continuously after reset → grant order m0, m1, m0, m1; no two consecutive grants to the same requester; no cycle with m0_valid and m1_valid both high.
- Timeout: TIMEOUT=4, memory never responds → mem_ready high for 4 cycles then low; m0_valid pulses with m0_rdata=0xFFFFFFFF; timeout_err pulses once in the same cycle; a late mem_valid afterwards produces no response.
- Race: mem_valid arrives in the same cycle the timer expires → normal response, timeout_err=0.
- Reset in ISSUE: assert reset while mem_ready=1 → mem_ready, busy and both valids go 0 asynchronously; after release, the first contended grant goes to m0.
